// File: rtl/regfile_pkg.sv
// Shared defaults and index helpers for the N-read / 1-write register file.
// Latency: none; this package holds only constants and pure functions.
// Backpressure: none; the package carries no flow control.
package regfile_pkg;

  localparam int DEF_WIDTH   = 64;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_HAS_ZR  = 1;
  localparam int DEF_BYPASS  = 1;
  localparam int DEF_REG_OUT = 0;

  // Address width for a given register count. The result is never below 1,
  // so the smallest file (2 entries) still has a real address bit.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // The last index is the one reserved as the hard-wired zero register.
  function automatic int zr_index(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: DEPTH:1 select, then same-cycle write forwarding, then zero-register mask.
// Latency: purely combinational from the storage array and the write-port inputs.
// Backpressure: none; the port always produces a value and any enable gating is done by the caller.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int HAS_ZR = DEF_HAS_ZR,
  parameter  int BYPASS = DEF_BYPASS,
  localparam int AW     = calc_aw(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [AW-1:0]               rd_addr,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            sel_data
);

  localparam logic [AW-1:0] ZR_IDX = AW'(zr_index(DEPTH));

  // Select the stored value. A matching write overrides it when forwarding
  // is enabled. The zero-register mask is applied last, so it also wins
  // over forwarded data.
  always_comb begin
    sel_data = regs[rd_addr];
    if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) begin
      sel_data = wr_data;
    end
    if ((HAS_ZR != 0) && (rd_addr == ZR_IDX)) begin
      sel_data = '0;
    end
  end

endmodule

// File: rtl/regfile_nr1w.sv
// Register file with NUM_RD independent read ports and one write port, optional zero register.
// Latency: a write is visible one clock later (same cycle if forwarding is on); reads are 0 or 1 cycle (REG_OUT).
// Backpressure: none; writes and reads are always accepted, and rd_valid qualifies the read data.
module regfile_nr1w
  import regfile_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int NUM_RD  = DEF_NUM_RD,
  parameter  int HAS_ZR  = DEF_HAS_ZR,
  parameter  int BYPASS  = DEF_BYPASS,
  parameter  int REG_OUT = DEF_REG_OUT,
  localparam int AW      = calc_aw(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid
);

  localparam logic [AW-1:0] ZR_IDX = AW'(zr_index(DEPTH));

  logic [DEPTH-1:0][WIDTH-1:0]  regs;
  logic [NUM_RD-1:0][WIDTH-1:0] sel_data;
  logic                         wr_hit_zr;

  // Writes aimed at the zero register are dropped so its storage stays 0.
  assign wr_hit_zr = (HAS_ZR != 0) && (wr_addr == ZR_IDX);

  // Storage: cleared by reset, and one entry updated per clock on a write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else if (wr_en && !wr_hit_zr) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    rf_read_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .HAS_ZR (HAS_ZR),
      .BYPASS (BYPASS)
    ) u_port (
      .regs     (regs),
      .rd_addr  (rd_addr[p]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .sel_data (sel_data[p])
    );
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_RD-1:0][WIDTH-1:0] data_q;
    logic [NUM_RD-1:0]            vld_q;

    // Output stage: data is captured only on a request and held otherwise;
    // valid follows the request one cycle late. Reset drops any pending read.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        vld_q <= rd_en;
        for (int p = 0; p < NUM_RD; p++) begin
          if (rd_en[p]) begin
            data_q[p] <= sel_data[p];
          end
        end
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = vld_q;
  end else begin : g_comb_out
    // Combinational output: a port that is not requested reads as 0.
    always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p] = sel_data[p];
        end
      end
    end

    assign rd_valid = rd_en;
  end

endmodule

// File: tb/tb_regfile_nr1w.sv
// Self-checking bench: one default instance (comb read, forwarding) and one registered, non-forwarding instance.
// Latency: the model predicts comb outputs in the same cycle and registered outputs one cycle later.
// Backpressure: none; inputs are driven on the falling edge and outputs are sampled mid-cycle.
module tb_regfile_nr1w;
  import regfile_pkg::*;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  wr_en = 1'b0;
  logic [AW-1:0]         wr_addr = '0;
  logic [W-1:0]          wr_data = '0;
  logic [NR-1:0]         rd_en = '0;
  logic [NR-1:0][AW-1:0] rd_addr = '0;
  logic [NR-1:0][W-1:0]  c_data, r_data;
  logic [NR-1:0]         c_vld, r_vld;

  always #5 clk = ~clk;

  regfile_nr1w dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(c_data), .rd_valid(c_vld)
  );

  regfile_nr1w #(.REG_OUT(1), .BYPASS(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(r_data), .rd_valid(r_vld)
  );

  // Reference model: plain array of register contents plus the expected
  // registered-port outputs.
  logic [W-1:0] mem [D];
  logic [W-1:0] m_rdata [NR];
  logic         m_rvld [NR];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Value a read of index a must return this cycle.
  function automatic logic [W-1:0] model_read(input int a, input bit bypass);
    if (a == D - 1) return '0;
    if (bypass && wr_en && (int'(wr_addr) == a)) return wr_data;
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) mem[i] = '0;
    for (int p = 0; p < NR; p++) begin
      m_rdata[p] = '0;
      m_rvld[p]  = 1'b0;
    end
  endtask

  // One clock: compare both instances against the model mid-cycle, then
  // advance the model at the rising edge and return at the falling edge.
  task automatic tick();
    #1;
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("comb_data[%0d]", p), c_data[p],
          rd_en[p] ? model_read(int'(rd_addr[p]), 1'b1) : '0);
      chk($sformatf("comb_vld[%0d]", p), W'(c_vld[p]), W'(rd_en[p]));
      chk($sformatf("reg_data[%0d]", p), r_data[p], m_rdata[p]);
      chk($sformatf("reg_vld[%0d]", p), W'(r_vld[p]), W'(m_rvld[p]));
    end
    @(posedge clk);
    if (reset_n) begin
      for (int p = 0; p < NR; p++) begin
        m_rvld[p] = rd_en[p];
        if (rd_en[p]) m_rdata[p] = model_read(int'(rd_addr[p]), 1'b0);
      end
      if (wr_en && int'(wr_addr) != D - 1) mem[wr_addr] = wr_data;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input int wa, input logic [W-1:0] wd,
                       input logic [NR-1:0] re, input int a0, input int a1);
    wr_en      = we;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    rd_en      = re;
    rd_addr[0] = AW'(a0);
    rd_addr[1] = AW'(a1);
  endtask

  initial begin
    model_reset();
    #1;
    chk("reset_reg_data0", r_data[0], '0);
    chk("reset_reg_vld", W'(r_vld), '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Every index reads back as zero after reset, on both ports.
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 0, '0, 2'b11, i, D - 1 - i);
      #1;
      chk("post_reset_read0", c_data[0], '0);
      chk("post_reset_read1", c_data[1], '0);
      tick();
    end

    // Write index 5, then read it on port 0 and index 6 on port 1.
    drive(1'b1, 5, 64'hDEAD_BEEF_0000_0001, 2'b00, 0, 0);
    tick();
    drive(1'b0, 0, '0, 2'b11, 5, 6);
    #1;
    chk("idx5_read", c_data[0], 64'hDEAD_BEEF_0000_0001);
    chk("idx6_read", c_data[1], '0);
    tick();
    chk("idx5_read_reg", r_data[0], 64'hDEAD_BEEF_0000_0001);

    // The zero register ignores writes and reads 0, even when forwarded.
    drive(1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 31, 0);
    #1;
    chk("zr_same_cycle", c_data[0], '0);
    tick();
    drive(1'b0, 0, '0, 2'b01, 31, 0);
    #1;
    chk("zr_next_cycle", c_data[0], '0);
    tick();
    chk("zr_reg", r_data[0], '0);

    // Same-cycle write and read of index 7: forwarding gives new data, the
    // non-forwarding instance captures the old value.
    drive(1'b1, 7, 64'h1234, 2'b11, 7, 7);
    #1;
    chk("bypass_p0", c_data[0], 64'h1234);
    chk("bypass_p1", c_data[1], 64'h1234);
    tick();
    chk("nobypass_old", r_data[0], '0);
    drive(1'b0, 0, '0, 2'b01, 7, 0);
    tick();
    chk("nobypass_next", r_data[0], 64'h1234);

    // Registered read pulse: valid for one cycle, data held afterwards.
    drive(1'b1, 3, 64'hAA, 2'b00, 0, 0);
    tick();
    drive(1'b0, 0, '0, 2'b01, 3, 0);
    tick();
    chk("pulse_vld", W'(r_vld[0]), 64'h1);
    chk("pulse_data", r_data[0], 64'hAA);
    drive(1'b0, 0, '0, 2'b00, 0, 0);
    tick();
    chk("pulse_vld_drop", W'(r_vld[0]), '0);
    chk("pulse_data_hold", r_data[0], 64'hAA);

    // Back-to-back writes to one index, each read in the same cycle.
    drive(1'b1, 9, 64'h1, 2'b01, 9, 0);
    #1;
    chk("b2b_first", c_data[0], 64'h1);
    tick();
    drive(1'b1, 9, 64'h2, 2'b11, 9, 9);
    #1;
    chk("b2b_second", c_data[1], 64'h2);
    tick();
    chk("b2b_reg_old", r_data[1], 64'h1);
    drive(1'b0, 0, '0, 2'b01, 9, 0);
    #1;
    chk("b2b_final", c_data[0], 64'h2);
    tick();

    // Asynchronous reset between clock edges, with a write pending.
    drive(1'b1, 2, 64'h55, 2'b00, 0, 0);
    tick();
    drive(1'b0, 0, '0, 2'b11, 2, 2);
    tick();
    chk("pre_reset_reg", r_data[0], 64'h55);
    drive(1'b1, 4, 64'h77, 2'b11, 2, 2);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_reg_data0", r_data[0], '0);
    chk("async_reg_data1", r_data[1], '0);
    chk("async_reg_vld", W'(r_vld), '0);
    chk("async_comb_data", c_data[0], '0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 0, '0, 2'b11, 2, 4);
    #1;
    chk("post_rel_idx2", c_data[0], '0);
    chk("post_rel_idx4", c_data[1], '0);
    chk("post_rel_vld", W'(r_vld), '0);
    tick();

    // Randomized traffic, biased toward address collisions and the zero register.
    for (int n = 0; n < 3000; n++) begin
      int wa;
      int a0;
      int a1;
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 31) : $urandom_range(0, 31);
      a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
            NR'($urandom_range(0, 3)), a0, a1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
